// File: rtl/mp3_volume_ctrl.sv
// Keyboard-driven volume controller: steps a volume class on up/down scancodes with auto-repeat
// and hands the resulting codec attenuation word to a writer via a req/ack handshake. Optional mute: MP3_VOL_MUTE_EN.
module mp3_volume_ctrl #(
    parameter int          LEVELS        = 10,
    parameter logic [7:0]  STEP          = 8'h19,
    parameter int          TICK_DIV      = 100000,
    parameter int          REPEAT_DELAY  = 4,
    parameter int          REPEAT_PERIOD = 2,
    parameter logic [7:0]  UP_CODE       = 8'h75,
    parameter logic [7:0]  DOWN_CODE     = 8'h72
`ifdef MP3_VOL_MUTE_EN
    ,
    parameter logic [7:0]  MUTE_CODE     = 8'h3A
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  code,
    input  logic        code_valid,
    input  logic        code_break,
    input  logic        upd_ack,
    output logic [15:0] vol,
    output logic [3:0]  volclass,
    output logic        upd_req
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
    localparam logic [3:0] TOP = 4'(LEVELS - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    state_t        state, state_n;
    logic [PW-1:0] pcnt;
    logic          tick;
    logic [7:0]    tcnt, tcnt_n, tcnt_inc;
    logic          dir_up, dir_n;
    logic          step;
    logic          make_ev, brk_ev, is_vol;
    logic [7:0]    held_code;
    logic          chg_p1;
    logic          upd_set;
    logic [7:0]    att_byte;

    function automatic logic [7:0] att_of(input logic [3:0] lvl);
        return 8'((LEVELS - 1 - int'(lvl)) * int'(STEP));
    endfunction

    // Stage 0: repeat-tick prescaler
    always_ff @(posedge clk) begin
        if (reset)            pcnt <= '0;
        else if (pcnt == PLAST) pcnt <= '0;
        else                  pcnt <= pcnt + 1'b1;
    end

    assign tick      = (pcnt == PLAST);
    assign make_ev   = code_valid && !code_break;
    assign brk_ev    = code_valid && code_break;
    assign is_vol    = (code == UP_CODE) || (code == DOWN_CODE);
    assign held_code = dir_up ? UP_CODE : DOWN_CODE;
    assign tcnt_inc  = tcnt + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            tcnt   <= '0;
            dir_up <= 1'b0;
        end else begin
            state  <= state_n;
            tcnt   <= tcnt_n;
            dir_up <= dir_n;
        end
    end

    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        dir_n   = dir_up;
        step    = 1'b0;
        case (state)
            IDLE: begin
                if (make_ev && is_vol) begin
                    step    = 1'b1;
                    dir_n   = (code == UP_CODE);
                    state_n = DELAY;
                    tcnt_n  = '0;
                end
            end
            DELAY, REPEAT: begin
                if (brk_ev && code == held_code) begin
                    state_n = IDLE;
                    tcnt_n  = '0;
                end else if (make_ev && is_vol && code != held_code) begin
                    // Opposite key while held: reverse and restart the repeat delay
                    step    = 1'b1;
                    dir_n   = (code == UP_CODE);
                    state_n = DELAY;
                    tcnt_n  = '0;
                end else if (tick) begin
                    if (state == DELAY && tcnt_inc == 8'(REPEAT_DELAY)) begin
                        step    = 1'b1;
                        state_n = REPEAT;
                        tcnt_n  = '0;
                    end else if (state == REPEAT && tcnt_inc == 8'(REPEAT_PERIOD)) begin
                        step    = 1'b1;
                        tcnt_n  = '0;
                    end else begin
                        tcnt_n  = tcnt_inc;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tcnt_n  = '0;
            end
        endcase
    end

    // Stage 1: level update with saturation; chg_p1 marks a real change
    always_ff @(posedge clk) begin
        if (reset) begin
            volclass <= TOP;
            chg_p1   <= 1'b0;
        end else begin
            chg_p1 <= 1'b0;
            if (step && dir_n && volclass != TOP) begin
                volclass <= volclass + 4'd1;
                chg_p1   <= 1'b1;
            end else if (step && !dir_n && volclass != 4'd0) begin
                volclass <= volclass - 4'd1;
                chg_p1   <= 1'b1;
            end
        end
    end

`ifdef MP3_VOL_MUTE_EN
    logic muted, mchg_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            muted   <= 1'b0;
            mchg_p1 <= 1'b0;
        end else begin
            mchg_p1 <= make_ev && (code == MUTE_CODE);
            if (make_ev && code == MUTE_CODE) muted <= ~muted;
        end
    end

    assign att_byte = muted ? 8'hFE : att_of(volclass);
    assign upd_set  = chg_p1 | mchg_p1;
`else
    assign att_byte = att_of(volclass);
    assign upd_set  = chg_p1;
`endif

    // Stage 2: codec word and pending-update handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            vol     <= 16'h0000;
            upd_req <= 1'b1;
        end else begin
            vol <= {att_byte, att_byte};
            if (upd_set)      upd_req <= 1'b1;
            else if (upd_ack) upd_req <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mp3_volume_ctrl.sv
// Directed self-checking bench for mp3_volume_ctrl (TICK_DIV=4, REPEAT_DELAY=3, REPEAT_PERIOD=2).
// Define MP3_VOL_MUTE_EN to exercise the mute feature.
module tb_mp3_volume_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  code;
    logic        code_valid;
    logic        code_break;
    logic        upd_ack;
    logic [15:0] vol;
    logic [3:0]  volclass;
    logic        upd_req;

    int n_checks = 0;
    int n_fail   = 0;
    int ecount   = 0;
    int m_edge;
    int t3;

    mp3_volume_ctrl #(
        .TICK_DIV(4),
        .REPEAT_DELAY(3),
        .REPEAT_PERIOD(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .code(code),
        .code_valid(code_valid),
        .code_break(code_break),
        .upd_ack(upd_ack),
        .vol(vol),
        .volclass(volclass),
        .upd_req(upd_req)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic key(input logic [7:0] c, input logic brk);
        code       = c;
        code_break = brk;
        code_valid = 1'b1;
        cycle();
        code_valid = 1'b0;
    endtask

    task automatic ack();
        upd_ack = 1'b1;
        cycle();
        upd_ack = 1'b0;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; code = 8'h00; code_valid = 1'b0; code_break = 1'b0; upd_ack = 1'b0;
        repeat (3) cycle();
        reset = 1'b0;
        ecount = 0;

        check("rst_volclass", 16'(volclass), 16'd9);
        check("rst_vol", vol, 16'h0000);
        check("rst_upd_req", 16'(upd_req), 16'd1);
        ack();
        check("ack_clears", 16'(upd_req), 16'd0);

        // single down step with quick release
        key(8'h72, 1'b0);
        cycle();
        key(8'h72, 1'b1);
        cycle();
        check("tap_volclass", 16'(volclass), 16'd8);
        check("tap_vol", vol, 16'h1919);
        check("tap_upd_req", 16'(upd_req), 16'd1);
        ack();
        repeat (20) cycle();
        check("tap_single_req", 16'(upd_req), 16'd0);
        check("tap_no_repeat", 16'(volclass), 16'd8);

        // held down key: auto-repeat timing and saturation
        key(8'h72, 1'b0);
        m_edge = ecount;
        check("hold_first", 16'(volclass), 16'd7);
        t3 = (m_edge / 4 + 3) * 4;
        while (ecount < t3 - 1) cycle();
        check("hold_pre_tick3", 16'(volclass), 16'd7);
        cycle();
        check("hold_tick3", 16'(volclass), 16'd6);
        cycle();
        check("hold_vol_tick3", vol, 16'h4B4B);
        repeat (150) cycle();
        check("sat_volclass", 16'(volclass), 16'd0);
        check("sat_vol", vol, 16'hE1E1);
        check("sat_pending", 16'(upd_req), 16'd1);
        ack();
        repeat (40) cycle();
        check("sat_no_req", 16'(upd_req), 16'd0);
        check("sat_still_0", 16'(volclass), 16'd0);
        key(8'h72, 1'b1);

        // back to loudest with taps, then try to go above
        repeat (9) begin
            key(8'h75, 1'b0);
            key(8'h75, 1'b1);
        end
        cycle();
        check("up9_volclass", 16'(volclass), 16'd9);
        check("up9_vol", vol, 16'h0000);
        ack();
        key(8'h75, 1'b0);
        repeat (20) cycle();
        check("top_sat_volclass", 16'(volclass), 16'd9);
        check("top_sat_no_req", 16'(upd_req), 16'd0);
        key(8'h75, 1'b1);

        // break of an unheld code must not end the hold
        key(8'h72, 1'b0);
        m_edge = ecount;
        key(8'h75, 1'b1);
        while (ecount < m_edge + 13) cycle();
        check("unheld_break", 16'(volclass), 16'd7);
        key(8'h72, 1'b1);
        ack();
        check("unheld_ack", 16'(upd_req), 16'd0);

        // change coincident with upd_ack
        key(8'h72, 1'b0);
        key(8'h72, 1'b1);
        key(8'h72, 1'b0);
        upd_ack = 1'b1;
        cycle();
        upd_ack = 1'b0;
        check("coinc_req", 16'(upd_req), 16'd1);
        check("coinc_vol", vol, 16'h6464);
        ack();
        check("coinc_ack", 16'(upd_req), 16'd0);
        key(8'h72, 1'b1);

`ifdef MP3_VOL_MUTE_EN
        key(8'h3A, 1'b0);
        cycle();
        check("mute_vol", vol, 16'hFEFE);
        check("mute_req", 16'(upd_req), 16'd1);
        check("mute_level", 16'(volclass), 16'd5);
        ack();
        key(8'h3A, 1'b1);
        key(8'h3A, 1'b0);
        cycle();
        check("unmute_vol", vol, 16'h6464);
        check("unmute_req", 16'(upd_req), 16'd1);
        ack();
`else
        key(8'h3A, 1'b0);
        repeat (3) cycle();
        check("other_code_vol", vol, 16'h6464);
        check("other_code_req", 16'(upd_req), 16'd0);
        check("other_code_level", 16'(volclass), 16'd5);
        key(8'h3A, 1'b1);
`endif

        // reset in the middle of a hold
        key(8'h72, 1'b0);
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        repeat (40) cycle();
        check("midhold_rst_level", 16'(volclass), 16'd9);
        check("midhold_rst_vol", vol, 16'h0000);
        check("midhold_rst_req", 16'(upd_req), 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mp3_volume_ctrl.md
MP3_VOLUME_CTRL -- requirements
Module: mp3_volume_ctrl

Interface
REQ-001 Parameter LEVELS, default 10: number of volume levels (2..16); level 0 is quietest, LEVELS-1 is loudest.
REQ-002 Parameter STEP, default 8'h19: attenuation per level; (LEVELS-1)*STEP SHALL be at most 255.
REQ-003 Parameter TICK_DIV, default 100000: clk cycles per repeat tick.
REQ-004 Parameter REPEAT_DELAY, default 4: ticks from key make to first auto-repeat.
REQ-005 Parameter REPEAT_PERIOD, default 2: ticks between subsequent auto-repeats.
REQ-006 Parameters UP_CODE, default 8'h75, and DOWN_CODE, default 8'h72: key scancodes.
REQ-007 clk  in  1  system clock; one clock domain; all logic on its rising edge.
REQ-008 reset  in  1  synchronous reset, active-high.
REQ-009 code  in  8  scancode from the upstream keyboard decoder.
REQ-010 code_valid  in  1  one-cycle strobe qualifying code and code_break.
REQ-011 code_break  in  1  1 = key release, 0 = key make.
REQ-012 upd_ack  in  1  codec writer has consumed vol.
REQ-013 vol  out  16  {left_att, right_att}, 8 bits each, equal values; 0 = loudest.
REQ-014 volclass  out  4  current level, 0..LEVELS-1.
REQ-015 upd_req  out  1  level-held request to write vol to the codec.

Function
REQ-016 Tick prescaler: free-running counter 0..TICK_DIV-1; one-cycle tick at wrap.
REQ-017 Attenuation SHALL be (LEVELS-1-volclass)*STEP, registered into both vol bytes the cycle after volclass changes.
REQ-018 Key FSM states: IDLE, DELAY, REPEAT; tick counter tcnt is cleared on every state entry.
REQ-019 IDLE: a valid make of UP_CODE/DOWN_CODE applies one step immediately, latches direction, enters DELAY.
REQ-020 DELAY: count ticks; at tcnt=REPEAT_DELAY apply one step, enter REPEAT.
REQ-021 REPEAT: count ticks; at tcnt=REPEAT_PERIOD apply one step and clear tcnt.
REQ-022 A valid break of the held code from DELAY or REPEAT SHALL return the FSM to IDLE with no step.
REQ-023 A make of the other volume code while held SHALL replace the direction, step once, and re-enter DELAY.
REQ-024 Breaks of unheld codes, and all other codes, SHALL be ignored.
REQ-025 Steps saturate: up at LEVELS-1 and down at 0 leave volclass unchanged and do not raise upd_req.
REQ-026 Every actual volclass change SHALL set upd_req one cycle later, together with the new vol.
REQ-027 upd_ack clears upd_req; if a change and upd_ack coincide, upd_req stays high; multiple changes coalesce into one pending request.
REQ-028 upd_ack while upd_req is low SHALL be ignored.

Reset
REQ-029 On reset: volclass=LEVELS-1, vol=16'h0000, upd_req=1 so the codec is initialised; FSM=IDLE; prescaler and tcnt=0.
REQ-030 Reset mid-hold SHALL abandon the hold; no steps follow until a new make.

Configuration
REQ-031 Macro MP3_VOL_MUTE_EN defined: parameter MUTE_CODE, default 8'h3A; each make toggles mute; while muted, vol=16'hFEFE and the held level is retained; unmute restores the level's attenuation; each toggle raises upd_req; volume keys still change volclass while muted, but vol stays 16'hFEFE.
REQ-032 Without MP3_VOL_MUTE_EN: no mute logic; MUTE_CODE is treated as any other ignored code.

Verification (TICK_DIV=4, REPEAT_DELAY=3, REPEAT_PERIOD=2, defaults otherwise)
REQ-033 Reset release -> volclass=9, vol=16'h0000, upd_req=1; upd_ack -> upd_req=0 next cycle.
REQ-034 Make 8'h72, break 2 cycles later -> volclass=8, vol=16'h1919, a single upd_req.
REQ-035 Hold 8'h72 for 30 ticks -> steps at make and at ticks 3, 5, 7, ...; volclass saturates at 0 with vol=16'hE1E1; no upd_req after saturation.
REQ-036 Level 9, make 8'h75 -> volclass stays 9, upd_req stays 0.
REQ-037 Change coincident with upd_ack -> upd_req remains 1; the next upd_ack clears it.
REQ-038 MP3_VOL_MUTE_EN: make 8'h3A -> vol=16'hFEFE, upd_req=1; make 8'h3A again -> original vol restored.
